// File: rtl/gnr_cycle_detector.sv
// gnr_cycle_detector: Floyd tortoise/hare sequencer and attractor-period meter for the GNR node array.
// Define GNR_CYCLE_SNAPSHOT_EN to add the attractor_state output (one captured attractor member).
module gnr_cycle_detector #(
    parameter int unsigned      WIDTH     = 188,
    parameter int unsigned      CNT_W     = 32,
    parameter logic [CNT_W-1:0] MAX_STEPS = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] s0_vec,
    input  logic [WIDTH-1:0] s1_vec,
    output logic             reset_nos,
    output logic             start_s0,
    output logic             start_s1,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] steps,
`ifdef GNR_CYCLE_SNAPSHOT_EN
    output logic [CNT_W-1:0] period,
    output logic [WIDTH-1:0] attractor_state
`else
    output logic [CNT_W-1:0] period
`endif
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT       = 3'd1,
        STEP_A     = 3'd2,
        STEP_B     = 3'd3,
        CHECK      = 3'd4,
        MEAS_STEP  = 3'd5,
        MEAS_CHECK = 3'd6,
        DONE       = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] steps_q, steps_d, period_q, period_d;
    logic [CNT_W-1:0] steps_inc, period_inc;
    logic             timeout_q, timeout_d;
    logic             reset_nos_q, reset_nos_d;
    logic             start_s0_q, start_s0_d;
    logic             start_s1_q, start_s1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             vec_eq;

    assign vec_eq     = (s0_vec == s1_vec);
    assign steps_inc  = (steps_q  == MAX_STEPS) ? steps_q  : steps_q  + CNT_W'(1);
    assign period_inc = (period_q == MAX_STEPS) ? period_q : period_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = INIT;
            INIT:       state_d = STEP_A;
            STEP_A:     state_d = STEP_B;
            STEP_B:     state_d = CHECK;
            CHECK: begin
                if (vec_eq)                      state_d = MEAS_STEP;
                else if (steps_inc == MAX_STEPS) state_d = DONE;
                else                             state_d = STEP_A;
            end
            MEAS_STEP:  state_d = MEAS_CHECK;
            MEAS_CHECK: begin
                if (vec_eq)                     state_d = DONE;
                else if (period_q == MAX_STEPS) state_d = DONE;
                else                            state_d = MEAS_STEP;
            end
            DONE:       if (start) state_d = INIT;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each strobe is high exactly while in its state.
    always_comb begin
        reset_nos_d = (state_d == INIT);
        start_s0_d  = (state_d == STEP_A) || (state_d == STEP_B);
        start_s1_d  = start_s0_d || (state_d == MEAS_STEP);
        busy_d      = !((state_d == IDLE) || (state_d == DONE));
        done_d      = (state_d == DONE);
    end

    always_comb begin
        steps_d   = steps_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        if (state_d == INIT) begin
            steps_d   = '0;
            period_d  = '0;
            timeout_d = 1'b0;
        end else begin
            if (state_q == CHECK)     steps_d  = steps_inc;
            if (state_q == MEAS_STEP) period_d = period_inc;
            if ((state_q == CHECK) && !vec_eq && (steps_inc == MAX_STEPS))
                timeout_d = 1'b1;
            if ((state_q == MEAS_CHECK) && !vec_eq && (period_q == MAX_STEPS))
                timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            steps_q     <= '0;
            period_q    <= '0;
        end else begin
            reset_nos_q <= reset_nos_d;
            start_s0_q  <= start_s0_d;
            start_s1_q  <= start_s1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            steps_q     <= steps_d;
            period_q    <= period_d;
        end
    end

    assign reset_nos = reset_nos_q;
    assign start_s0  = start_s0_q;
    assign start_s1  = start_s1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign steps     = steps_q;
    assign period    = period_q;

`ifdef GNR_CYCLE_SNAPSHOT_EN
    logic [WIDTH-1:0] attractor_q, attractor_d;

    // At the first meeting the tortoise already sits on the cycle.
    always_comb begin
        attractor_d = attractor_q;
        if (state_d == INIT)
            attractor_d = '0;
        else if ((state_q == CHECK) && (state_d == MEAS_STEP))
            attractor_d = s0_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            attractor_q <= '0;
        end else begin
            attractor_q <= attractor_d;
        end
    end

    assign attractor_state = attractor_q;
`endif

endmodule

// File: tb/tb_gnr_cycle_detector.sv
// tb_gnr_cycle_detector: directed runs against a behavioural node array, scoreboard-checked on done.
module tb_gnr_cycle_detector;

    localparam int              W    = 5;
    localparam int              CW   = 32;
    localparam logic [CW-1:0]   MAXS = 32'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  s0_vec, s1_vec;
    logic          reset_nos, start_s0, start_s1, busy, done, timeout;
    logic [CW-1:0] steps, period;
`ifdef GNR_CYCLE_SNAPSHOT_EN
    logic [W-1:0]  attractor_state;
`endif

    gnr_cycle_detector #(.WIDTH(W), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s0_vec    (s0_vec),
        .s1_vec    (s1_vec),
        .reset_nos (reset_nos),
        .start_s0  (start_s0),
        .start_s1  (start_s1),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .steps     (steps),
`ifdef GNR_CYCLE_SNAPSHOT_EN
        .period    (period),
        .attractor_state (attractor_state)
`else
        .period    (period)
`endif
    );

    always #5 clk = ~clk;

    // Node array model: 0 identity, 1 rotate-left in 4 bits, 2 0..4 then back to 2, 3 free counter
    int           mode = 0;
    logic [W-1:0] init_val = '0;
    logic [W-1:0] n_s0 = '0, n_s1 = '0;
    logic         n_pass = 1'b1;

    function automatic logic [W-1:0] f_next(input int m, input logic [W-1:0] x);
        case (m)
            0:       return x;
            1:       return {1'b0, x[2:0], x[3]};
            2:       return (x == 5'd4) ? 5'd2 : x + 5'd1;
            default: return x + 5'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            n_s0   <= init_val;
            n_s1   <= init_val;
            n_pass <= 1'b1;
        end else if (start_s0 && start_s1) begin
            n_s1 <= f_next(mode, n_s1);
            if (n_pass) n_s0 <= f_next(mode, n_s0);
            n_pass <= ~n_pass;
        end else if (start_s1) begin
            n_s1 <= f_next(mode, n_s1);
        end
    end

    assign s0_vec = n_s0;
    assign s1_vec = n_s1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Enable-pattern counters, sampled at posedge (values of the cycle just ended)
    int   cyc = 0;
    int   cnt_both = 0, cnt_s1o = 0, cnt_s0o = 0, cnt_rst = 0;
    logic clr = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (clr) begin
            cnt_both = 0; cnt_s1o = 0; cnt_s0o = 0; cnt_rst = 0;
        end else begin
            if (start_s0 && start_s1)  cnt_both++;
            if (!start_s0 && start_s1) cnt_s1o++;
            if (start_s0 && !start_s1) cnt_s0o++;
            if (reset_nos)             cnt_rst++;
        end
    end

    typedef struct {
        logic [CW-1:0] st;
        logic [CW-1:0] pr;
        logic          to;
        logic [W-1:0]  at;
        int            lat;
        int            both;
        int            s1o;
    } exp_t;

    exp_t exp_q[$];
    int   start_cyc = 0;

    initial begin : monitor
        exp_t e;
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    e = exp_q.pop_front();
                    chk("steps",    steps,               e.st);
                    chk("period",   period,              e.pr);
                    chk("timeout",  timeout,             e.to);
                    chk("busy_off", busy,                1'b0);
                    chk("latency",  cyc - start_cyc,     e.lat);
                    chk("en_both",  cnt_both,            e.both);
                    chk("en_s1",    cnt_s1o,             e.s1o);
                    chk("en_s0",    cnt_s0o,             0);
                    chk("rst_nos",  cnt_rst,             1);
`ifdef GNR_CYCLE_SNAPSHOT_EN
                    chk("attractor", attractor_state,    e.at);
`endif
                end
            end
            done_prev = done;
        end
    end

    task automatic start_run(input int m, input logic [W-1:0] iv, input exp_t e);
        mode     = m;
        init_val = iv;
        exp_q.push_back(e);
        start = 1'b1;
        clr   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        clr       = 1'b0;
        start_cyc = cyc;
        chk("init_reset_nos", reset_nos, 1'b1);
        chk("init_busy",      busy,      1'b1);
        chk("init_done",      done,      1'b0);
        chk("init_clear",     {timeout, steps, period}, '0);
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        n_vec++; n_err++;
        $display("FAIL wait_done: got no done within %0d cycles expected done", maxc);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        bit   seen;

        repeat (3) @(negedge clk);
        chk("rst_outputs", {reset_nos, start_s0, start_s1, busy, done, timeout}, '0);
        chk("rst_counts",  {steps, period}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {busy, done}, 2'b00);

        // Reset in the middle of STEP_A
        mode = 0; init_val = 5'b00111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (start_s0) seen = 1;
            else @(negedge clk);
        end
        chk("reach_step_a", seen, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_outputs", {reset_nos, start_s0, start_s1, busy, done, timeout}, '0);
        chk("midrun_rst_counts",  {steps, period}, '0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_enables", cnt_both + cnt_s1o + cnt_s0o + cnt_rst, 0);
        chk("post_rst_idle", {busy, done}, 2'b00);

        // Fixed point
        e = '{st: 32'd1, pr: 32'd1, to: 1'b0, at: 5'b10110, lat: 6, both: 2, s1o: 1};
        start_run(0, 5'b10110, e);
        wait_done(100);

        // Pure 4-cycle, with a start issued while busy
        e = '{st: 32'd4, pr: 32'd4, to: 1'b0, at: 5'b00001, lat: 21, both: 8, s1o: 4};
        start_run(1, 5'b00001, e);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);

        // Transient of two then cycle {2,3,4}
        e = '{st: 32'd3, pr: 32'd3, to: 1'b0, at: 5'd3, lat: 16, both: 6, s1o: 3};
        start_run(2, 5'd0, e);
        wait_done(100);

        // No repeat: hits the iteration limit
        e = '{st: 32'd5, pr: 32'd0, to: 1'b1, at: 5'd0, lat: 16, both: 10, s1o: 0};
        start_run(3, 5'd0, e);
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("done_held", {done, timeout, busy}, 3'b110);

        // Restart from DONE: same results as the earlier transient run
        e = '{st: 32'd3, pr: 32'd3, to: 1'b0, at: 5'd3, lat: 16, both: 6, s1o: 3};
        start_run(2, 5'd0, e);
        wait_done(100);

        repeat (3) @(negedge clk);
        chk("pending_expect", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
